// File: rtl/wb_writeback_if.sv
// Bundle of MEM-side inputs, data-bus return and register-file write port for
// the write-back stage.
interface wb_writeback_if;
  logic        mem_valid_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_rmem_i;
  logic [2:0]  mem_load_type_i;
  logic [1:0]  mem_addr_lo_i;
  logic        flush_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        wb_stall_o;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        dbg_state_o;

  modport slave (
    input  mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i, mem_rmem_i,
           mem_load_type_i, mem_addr_lo_i, flush_i, dbus_rvalid_i, dbus_rdata_i,
    output wb_stall_o, wb_we_o, wb_waddr_o, wb_wdata_o, dbg_state_o
  );

  modport master (
    output mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i, mem_rmem_i,
           mem_load_type_i, mem_addr_lo_i, flush_i, dbus_rvalid_i, dbus_rdata_i,
    input  wb_stall_o, wb_we_o, wb_waddr_o, wb_wdata_o, dbg_state_o
  );
endinterface

// File: rtl/wb_writeback.sv
// MIPS write-back stage: registers retiring results, waits for load data and
// extends it, and stalls upstream stages while a load is outstanding.
module wb_writeback (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_writeback_if.slave bus
);
  // Handshake: MEM offers an instruction with mem_valid_i; it is taken on a rising
  // edge when the stage is IDLE and flush_i is low. In WAIT, wb_stall_o holds MEM
  // steady and the single-cycle dbus_rvalid_i pulse completes the pending load.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        pend_we;
  logic [4:0]  pend_addr;
  logic [2:0]  pend_type;
  logic [1:0]  pend_lo;
  logic        accept;
  logic [31:0] load_data;

  function automatic logic [31:0] extract(input logic [2:0]  ltype,
                                          input logic [1:0]  lo,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    // Halfword alignment is guaranteed upstream, so only lo[1] selects the half.
    h = lo[1] ? d[31:16] : d[15:0];
    case (ltype)
      3'd1:    r = {{24{b[7]}}, b};
      3'd2:    r = {24'd0, b};
      3'd3:    r = {{16{h[15]}}, h};
      3'd4:    r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept    = (state == IDLE) && bus.mem_valid_i && !bus.flush_i;
  assign load_data = extract(pend_type, pend_lo, bus.dbus_rdata_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= 32'd0;
      pend_we   <= 1'b0;
      pend_addr <= 5'd0;
      pend_type <= 3'd0;
      pend_lo   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          we_q <= 1'b0;
          if (accept) begin
            if (bus.mem_rmem_i) begin
              // Non-writing loads still wait so their data pulse is consumed.
              pend_we   <= bus.mem_wreg_i && (bus.mem_waddr_i != 5'd0);
              pend_addr <= bus.mem_waddr_i;
              pend_type <= bus.mem_load_type_i;
              pend_lo   <= bus.mem_addr_lo_i;
              state     <= WAIT;
            end else begin
              we_q    <= bus.mem_wreg_i && (bus.mem_waddr_i != 5'd0);
              waddr_q <= bus.mem_waddr_i;
              wdata_q <= bus.mem_wdata_i;
            end
          end
        end
        WAIT: begin
          we_q <= 1'b0;
          if (bus.dbus_rvalid_i) begin
            we_q    <= pend_we;
            waddr_q <= pend_addr;
            wdata_q <= load_data;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wb_stall_o  = (state == WAIT);
  assign bus.wb_we_o     = we_q;
  assign bus.wb_waddr_o  = waddr_q;
  assign bus.wb_wdata_o  = wdata_q;
  assign bus.dbg_state_o = state;
endmodule

// File: doc/wb_writeback.md
# wb_writeback

Write-back stage of the five-stage MIPS pipeline. It is the producer end of the register-file write port and the WB forwarding path that the decode stage consumes (`wb_we`/`wb_waddr`/`wb_wdata`). It registers retiring instructions from MEM and extracts and extends load data returned by the data bus. It stalls the pipeline while a load's data is outstanding.

## Interface
Parameters:
- none; fixed MIPS32 widths: 32-bit data, 5-bit register address.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- mem_valid_i  in  1  MEM holds a retiring instruction this cycle
- mem_wreg_i  in  1  instruction writes a GPR
- mem_waddr_i  in  5  destination GPR
- mem_wdata_i  in  32  ALU/link result for non-loads
- mem_rmem_i  in  1  instruction is a load
- mem_load_type_i  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU; 5-7 are treated as LW
- mem_addr_lo_i  in  2  byte offset of the load address
- flush_i  in  1  exception/eret flush; blocks acceptance this cycle
- dbus_rvalid_i  in  1  load data valid (single-cycle pulse)
- dbus_rdata_i  in  32  load data word, little-endian
- wb_stall_o  out  1  stall request to IF..MEM
- wb_we_o  out  1  register-file write enable / WB forward valid
- wb_waddr_o  out  5  write address
- wb_wdata_o  out  32  write data

## Operation
- FSM states: IDLE and WAIT.
- Accept condition: state==IDLE && mem_valid_i && !flush_i.

IDLE:
- On accept of a non-load: next cycle wb_we_o = mem_wreg_i && (mem_waddr_i != 0); wb_waddr_o = mem_waddr_i; wb_wdata_o = mem_wdata_i.
- On accept of a load with mem_wreg_i: capture waddr, load_type and addr_lo; go to WAIT; next cycle wb_we_o = 0.
- On accept of a load with mem_wreg_i = 0 or waddr = 0: the load is still tracked through WAIT so that its data pulse is consumed, but it never writes.
- No accept: next cycle wb_we_o = 0; wb_waddr_o and wb_wdata_o hold their previous values.

WAIT:
- wb_stall_o = 1 (combinational from state). mem_valid_i, flush_i and MEM fields are ignored.
- dbus_rvalid_i = 1: next cycle wb_we_o = captured write flag; wb_waddr_o = captured addr; wb_wdata_o = extracted data; state returns to IDLE.
- dbus_rvalid_i = 0: remain in WAIT; wb_we_o = 0.

Data extraction:
- LW: the whole word.
- LB/LBU: byte[8*lo +: 8], sign- or zero-extended to 32 bits.
- LH/LHU: half[16*lo[1] +: 16], sign- or zero-extended; lo[0] is ignored because alignment is checked upstream.

Other rules:
- dbus_rvalid_i while in IDLE is spurious: ignored, no write.
- flush_i never aborts a load that is already in WAIT. Loads reaching WB are committed.

## Timing
- Reset (asynchronous assert, registered outputs): state=IDLE, wb_we_o=0, wb_waddr_o=0, wb_wdata_o=0, wb_stall_o=0. Reset during WAIT discards the pending load.
- Non-load latency: accept at edge N, write visible during cycle N+1 (one register stage).
- Load latency: accept at N; WAIT from N+1; rvalid sampled at edge M gives the write during cycle M+1 with wb_stall_o=0.
- Minimum load latency is 2 cycles (rvalid at N+1).
- wb_stall_o is high from N+1 through the cycle in which rvalid is sampled.
- The next instruction is accepted at edge M+1, the same edge that completes the load write. Its own write appears at M+2, so there is never a double write in one cycle.
- Back-to-back non-loads give one write per cycle with no bubbles.

## Test plan
- Reset low mid-WAIT -> all outputs 0 immediately, state IDLE; the later rvalid is ignored and produces no write.
- Non-load stream $3=0x11, $4=0x22, $0=0x33 on consecutive cycles -> wb_we_o 1,1,0 on the following cycles, addr/data 3/0x11 then 4/0x22; $0 is suppressed.
- LB $5, lo=3, rdata=0x80FF1234, rvalid 3 cycles after accept -> wb_stall_o high exactly 3 cycles, then wb_we_o=1, $5=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LH lo=2 then LHU lo=0 with rdata=0x8001_F00F, rvalid the cycle after accept -> 0xFFFF8001, then 0x0000F00F; stall 1 cycle each.
- flush_i with mem_valid_i in IDLE -> no write next cycle; flush_i asserted during WAIT -> the load still writes.
- Load immediately followed by a held ALU instruction -> the load write and the ALU write land in consecutive cycles with no overlap, and the ALU instruction's data is the value presented while stalled.
